// File: rtl/bcd_to_binary_converter.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_converter
//
// Converts a three-digit BCD number (hundreds/tens/ones) into a 9-bit binary
// value using a small sequential multiply-accumulate: acc = acc*10 + digit,
// one digit per cycle, most significant digit first.
//
// The digits are captured when a conversion starts and then checked for
// validity. A digit above 9 short-circuits straight to the result with the
// invalid flag set. Results above 511 raise overflow. Depending on
// SAT_ON_OVF, the reported value then either saturates at 511 or carries the
// low 9 bits of the decimal result.
//
// Parameters
//   SAT_ON_OVF  1: value saturates to 511 on overflow
//               0: value carries the low 9 bits of the decimal result
//
// Ports
//   clk       in   1  system clock, all state updates on the rising edge
//   reset     in   1  synchronous active-high reset
//   start     in   1  conversion request, only looked at while idle
//   bcd0      in   4  ones digit
//   bcd1      in   4  tens digit
//   bcd2      in   4  hundreds digit
//   busy      out  1  conversion in progress (CHECK / ACC2 / ACC1 / ACC0)
//   done      out  1  one-cycle pulse, result outputs are valid
//   value     out  9  binary result, held until the next done
//   overflow  out  1  decimal result exceeded 511, held with value
//   invalid   out  1  a captured digit was above 9, held with value
// -----------------------------------------------------------------------------
module bcd_to_binary_converter #(
    parameter int SAT_ON_OVF = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    output logic       busy,
    output logic       done,
    output logic [8:0] value,
    output logic       overflow,
    output logic       invalid
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ACC2  = 3'd2,
        ACC1  = 3'd3,
        ACC0  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [9:0] MAX_VALUE = 10'd511;

    state_t     state;
    logic [3:0] dig2;
    logic [3:0] dig1;
    logic [3:0] dig0;
    logic [9:0] acc;

    // Datapath helpers, evaluated every cycle from the current state.
    logic [3:0] digit;        // digit consumed by the current ACC state
    logic [9:0] acc_next;     // acc*10 + digit
    logic       digit_bad;    // any captured digit is not a decimal digit
    logic       ovf_next;     // final result exceeds the 9-bit range
    logic [8:0] value_next;   // reported value for a valid conversion

    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        digit = 4'd0;
        case (state)
            ACC2:    digit = dig2;
            ACC1:    digit = dig1;
            ACC0:    digit = dig0;
            default: digit = 4'd0;
        endcase

        // Ten-bit arithmetic is enough: acc never exceeds 99 when it is
        // multiplied, so the largest result is 99*10 + 9 = 999.
        acc_next  = (acc * 10'd10) + {6'd0, digit};

        digit_bad = (dig2 > 4'd9) || (dig1 > 4'd9) || (dig0 > 4'd9);

        ovf_next  = (acc_next > MAX_VALUE);
        if ((SAT_ON_OVF != 0) && ovf_next) begin
            value_next = 9'd511;
        end else begin
            value_next = acc_next[8:0];
        end
    end

    // Single sequential block: state, datapath registers and the registered
    // outputs all move together.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others regardless of the
    // order of the statements below.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the captured digits and acc are cleared as well, even
            // though they are overwritten before use, so that the whole block
            // is in a known state straight after reset.
            state    <= IDLE;
            dig2     <= 4'd0;
            dig1     <= 4'd0;
            dig0     <= 4'd0;
            acc      <= 10'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            value    <= 9'd0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Capture the digits now; the inputs are free to
                        // change for the rest of the conversion.
                        dig2  <= bcd2;
                        dig1  <= bcd1;
                        dig0  <= bcd0;
                        acc   <= 10'd0;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    if (digit_bad) begin
                        // Skip the accumulation and report a zero result.
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        value    <= 9'd0;
                        overflow <= 1'b0;
                        invalid  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= ACC2;
                    end
                end

                ACC2: begin
                    acc   <= acc_next;
                    state <= ACC1;
                end

                ACC1: begin
                    acc   <= acc_next;
                    state <= ACC0;
                end

                ACC0: begin
                    // The result outputs only ever change on the edge that
                    // enters DONE, here or in CHECK.
                    acc      <= acc_next;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    value    <= value_next;
                    overflow <= ovf_next;
                    invalid  <= 1'b0;
                    state    <= DONE;
                end

                DONE: begin
                    // start is not looked at here, so a request that arrives
                    // while a conversion is in flight is simply dropped.
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
